// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, branch funct3 codes, ALU operations,
// write-back select encoding and the ID/EX pipeline record.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // All-zero value of this record is the bubble (ALU_ADD encodes as 0)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  wb_sel;
    } idex_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    // SUB only exists for register-register ops; bit 30 selects SRA/SRAI for either
    function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear, optional same-cycle write-back bypass.
module register_file #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs_r [32];

    // Storage update; entry 0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 1 with write-back bypass
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = 32'd0;
        end else if (WB_BYPASS && we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_r[raddr1];
        end
    end

    // Read port 2 with write-back bypass
    always_comb begin
        if (raddr2 == 5'd0) begin
            rdata2 = 32'd0;
        end else if (WB_BYPASS && we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_r[raddr2];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I ID stage: register read with MEM/WB forwarding, decode, branch/jump
// resolution back to fetch, one-slot squash, and the ID/EX pipeline register.
module instruction_decode #(
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_if,
    input  logic [31:0] instruction_address_if,
    input  logic        reg_write_wb,
    input  logic [4:0]  rd_wb,
    input  logic [31:0] rd_data_wb,
    input  logic        reg_write_mem,
    input  logic        mem_read_mem,
    input  logic [4:0]  rd_mem,
    input  logic [31:0] alu_result_mem,
    output logic        jump_flag_id,
    output logic [31:0] jump_address_id,
    output logic [31:0] pc_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [4:0]  rd_ex,
    output logic [2:0]  funct3_ex,
    output logic [3:0]  alu_op_ex,
    output logic        alu_src_a_ex,
    output logic        alu_src_b_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        reg_write_ex,
    output logic [1:0]  wb_sel_ex
);
    import rv32_pkg::*;

    logic [31:0] pc_id_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_idx_s, rs2_idx_s, rd_idx_s;
    logic [31:0] rf_rs1_s, rf_rs2_s, rs1_val_s, rs2_val_s;
    logic        mem_fwd_ok_s, branch_cond_s, jump_taken_s, kill_s;
    logic [31:0] jump_target_s;
    idex_t       decoded_s, idex_next_s, idex_r;
    logic        squash_r;

    assign pc_id_s   = instruction_address_if - 32'd4;
    assign opcode_s  = instruction_if[6:0];
    assign funct3_s  = instruction_if[14:12];
    assign rs1_idx_s = instruction_if[19:15];
    assign rs2_idx_s = instruction_if[24:20];
    assign rd_idx_s  = instruction_if[11:7];

    register_file #(.WB_BYPASS(WB_BYPASS)) u_register_file (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_write_wb),
        .waddr  (rd_wb),
        .wdata  (rd_data_wb),
        .raddr1 (rs1_idx_s),
        .rdata1 (rf_rs1_s),
        .raddr2 (rs2_idx_s),
        .rdata2 (rf_rs2_s)
    );

    // A load in MEM only holds an address, so it is never a forwarding source
    assign mem_fwd_ok_s = reg_write_mem && !mem_read_mem && (rd_mem != 5'd0);

    // Per-operand source select: MEM result over register file (which carries WB bypass)
    always_comb begin
        if (mem_fwd_ok_s && (rd_mem == rs1_idx_s)) begin
            rs1_val_s = alu_result_mem;
        end else begin
            rs1_val_s = rf_rs1_s;
        end
        if (mem_fwd_ok_s && (rd_mem == rs2_idx_s)) begin
            rs2_val_s = alu_result_mem;
        end else begin
            rs2_val_s = rf_rs2_s;
        end
    end

    // Branch condition; reserved funct3 codes never take
    always_comb begin
        branch_cond_s = 1'b0;
        case (funct3_s)
            F3_BEQ:  branch_cond_s = (rs1_val_s == rs2_val_s);
            F3_BNE:  branch_cond_s = (rs1_val_s != rs2_val_s);
            F3_BLT:  branch_cond_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
            F3_BGE:  branch_cond_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            F3_BLTU: branch_cond_s = (rs1_val_s <  rs2_val_s);
            F3_BGEU: branch_cond_s = (rs1_val_s >= rs2_val_s);
            default: branch_cond_s = 1'b0;
        endcase
    end

    // Redirect resolution
    always_comb begin
        jump_taken_s  = 1'b0;
        jump_target_s = 32'd0;
        case (opcode_s)
            OPC_JAL: begin
                jump_taken_s  = 1'b1;
                jump_target_s = pc_id_s + imm_j(instruction_if);
            end
            OPC_JALR: begin
                jump_taken_s  = 1'b1;
                jump_target_s = (rs1_val_s + imm_i(instruction_if)) & ~32'd1;
            end
            OPC_BRANCH: begin
                jump_taken_s  = branch_cond_s;
                jump_target_s = pc_id_s + imm_b(instruction_if);
            end
            default: begin
                jump_taken_s  = 1'b0;
                jump_target_s = 32'd0;
            end
        endcase
    end

    assign jump_flag_id    = jump_taken_s && !squash_r && !rst;
    assign jump_address_id = jump_flag_id ? jump_target_s : 32'd0;

    // Field decode; branches and illegal opcodes leave the bubble in place
    always_comb begin
        decoded_s = '0;
        case (opcode_s)
            OPC_LUI: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.imm = imm_u(instruction_if);
                decoded_s.alu_op = ALU_PASS_B;  decoded_s.alu_src_b = 1'b1;
                decoded_s.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.imm = imm_u(instruction_if);
                decoded_s.alu_src_a = 1'b1;  decoded_s.alu_src_b = 1'b1;
                decoded_s.reg_write = 1'b1;
            end
            OPC_JAL: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.imm = imm_j(instruction_if);
                decoded_s.alu_src_a = 1'b1;  decoded_s.alu_src_b = 1'b1;
                decoded_s.reg_write = 1'b1;  decoded_s.wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.rs1 = rs1_idx_s;  decoded_s.rs1_data = rs1_val_s;
                decoded_s.funct3 = funct3_s;  decoded_s.imm = imm_i(instruction_if);
                decoded_s.alu_src_b = 1'b1;
                decoded_s.reg_write = 1'b1;  decoded_s.wb_sel = WB_PC4;
            end
            OPC_LOAD: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.rs1 = rs1_idx_s;  decoded_s.rs1_data = rs1_val_s;
                decoded_s.funct3 = funct3_s;  decoded_s.imm = imm_i(instruction_if);
                decoded_s.alu_src_b = 1'b1;  decoded_s.mem_read = 1'b1;
                decoded_s.reg_write = 1'b1;  decoded_s.wb_sel = WB_MEM;
            end
            OPC_STORE: begin
                decoded_s.pc = pc_id_s;
                decoded_s.rs1 = rs1_idx_s;  decoded_s.rs1_data = rs1_val_s;
                decoded_s.rs2 = rs2_idx_s;  decoded_s.rs2_data = rs2_val_s;
                decoded_s.funct3 = funct3_s;  decoded_s.imm = imm_s(instruction_if);
                decoded_s.alu_src_b = 1'b1;  decoded_s.mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.rs1 = rs1_idx_s;  decoded_s.rs1_data = rs1_val_s;
                decoded_s.funct3 = funct3_s;  decoded_s.imm = imm_i(instruction_if);
                decoded_s.alu_op = alu_op_decode(funct3_s, instruction_if[30], 1'b0);
                decoded_s.alu_src_b = 1'b1;  decoded_s.reg_write = 1'b1;
            end
            OPC_OP: begin
                decoded_s.pc = pc_id_s;  decoded_s.rd = rd_idx_s;
                decoded_s.rs1 = rs1_idx_s;  decoded_s.rs1_data = rs1_val_s;
                decoded_s.rs2 = rs2_idx_s;  decoded_s.rs2_data = rs2_val_s;
                decoded_s.funct3 = funct3_s;
                decoded_s.alu_op = alu_op_decode(funct3_s, instruction_if[30], 1'b1);
                decoded_s.reg_write = 1'b1;
            end
            default: decoded_s = '0;
        endcase
    end

    assign kill_s = squash_r || (instruction_if == NOP_INSTR);

    // Wrong-path slot and canonical NOP both enter EX as a bubble
    always_comb begin
        if (kill_s) begin
            idex_next_s = '0;
        end else begin
            idex_next_s = decoded_s;
        end
    end

    // ID/EX pipeline register and wrong-path squash flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_r   <= '0;
            squash_r <= 1'b0;
        end else begin
            idex_r   <= idex_next_s;
            squash_r <= jump_flag_id;
        end
    end

    assign pc_ex        = idex_r.pc;
    assign rs1_data_ex  = idex_r.rs1_data;
    assign rs2_data_ex  = idex_r.rs2_data;
    assign imm_ex       = idex_r.imm;
    assign rs1_ex       = idex_r.rs1;
    assign rs2_ex       = idex_r.rs2;
    assign rd_ex        = idex_r.rd;
    assign funct3_ex    = idex_r.funct3;
    assign alu_op_ex    = idex_r.alu_op;
    assign alu_src_a_ex = idex_r.alu_src_a;
    assign alu_src_b_ex = idex_r.alu_src_b;
    assign mem_read_ex  = idex_r.mem_read;
    assign mem_write_ex = idex_r.mem_write;
    assign reg_write_ex = idex_r.reg_write;
    assign wb_sel_ex    = idex_r.wb_sel;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed plus randomized bench for instruction_decode, checked against an
// instruction-level reference model of the ID stage.
module tb_instruction_decode;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_if, instruction_address_if;
    logic        reg_write_wb;
    logic [4:0]  rd_wb;
    logic [31:0] rd_data_wb;
    logic        reg_write_mem, mem_read_mem;
    logic [4:0]  rd_mem;
    logic [31:0] alu_result_mem;
    logic        jump_flag_id;
    logic [31:0] jump_address_id, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [2:0]  funct3_ex;
    logic [3:0]  alu_op_ex;
    logic        alu_src_a_ex, alu_src_b_ex, mem_read_ex, mem_write_ex, reg_write_ex;
    logic [1:0]  wb_sel_ex;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic        sa, sb, mr, mw, rw;
        logic [1:0]  wb;
    } exp_t;

    logic [31:0] regs_m [32];
    bit          squash_m;
    alu_op_e     alu_tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    instruction_decode dut (
        .clk(clk), .rst(rst),
        .instruction_if(instruction_if), .instruction_address_if(instruction_address_if),
        .reg_write_wb(reg_write_wb), .rd_wb(rd_wb), .rd_data_wb(rd_data_wb),
        .reg_write_mem(reg_write_mem), .mem_read_mem(mem_read_mem), .rd_mem(rd_mem),
        .alu_result_mem(alu_result_mem),
        .jump_flag_id(jump_flag_id), .jump_address_id(jump_address_id),
        .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .funct3_ex(funct3_ex),
        .alu_op_ex(alu_op_ex), .alu_src_a_ex(alu_src_a_ex), .alu_src_b_ex(alu_src_b_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex), .reg_write_ex(reg_write_ex),
        .wb_sel_ex(wb_sel_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3);
        logic [12:0] m = 13'(imm);
        return {m[12], m[10:5], r2, r1, f3, m[4:1], m[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        logic [20:0] m = 21'(imm);
        return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
    endfunction

    // Operand as the ID stage should see it: MEM ALU result, then WB data, then architectural file
    function automatic logic [31:0] opnd(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (reg_write_mem && !mem_read_mem && rd_mem == idx) return alu_result_mem;
        if (reg_write_wb && rd_wb == idx) return rd_data_wb;
        return regs_m[idx];
    endfunction

    function automatic logic [31:0] ii(input logic [31:0] x); return 32'($signed(x) >>> 20); endfunction
    function automatic logic [31:0] is_(input logic [31:0] x); return {{20{x[31]}}, x[31:25], x[11:7]}; endfunction
    function automatic logic [31:0] ib(input logic [31:0] x); return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0}; endfunction
    function automatic logic [31:0] iu(input logic [31:0] x); return x & 32'hFFFF_F000; endfunction
    function automatic logic [31:0] ij(input logic [31:0] x); return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0}; endfunction

    // Expected redirect {flag, address}
    function automatic logic [32:0] model_jump(input logic [31:0] x, input logic [31:0] pc);
        logic [31:0] a, b;
        bit t;
        if (squash_m) return 33'd0;
        a = opnd(x[19:15]);
        b = opnd(x[24:20]);
        case (x[6:0])
            7'b1101111: return {1'b1, pc + ij(x)};
            7'b1100111: return {1'b1, (a + ii(x)) & 32'hFFFF_FFFE};
            7'b1100011: begin
                case (x[14:12])
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) <  $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a <  b);
                    3'd7: t = (a >= b);
                    default: t = 1'b0;
                endcase
                return t ? {1'b1, pc + ib(x)} : 33'd0;
            end
            default: return 33'd0;
        endcase
    endfunction

    // Expected ID/EX contents
    function automatic exp_t model_decode(input logic [31:0] x, input logic [31:0] pc);
        exp_t e = '0;
        logic [2:0] f3 = x[14:12];
        if (squash_m || x == 32'h0000_0013) return e;
        case (x[6:0])
            7'b0110111: begin e.pc = pc; e.rd = x[11:7]; e.imm = iu(x); e.op = ALU_PASS_B; e.sb = 1'b1; e.rw = 1'b1; end
            7'b0010111: begin e.pc = pc; e.rd = x[11:7]; e.imm = iu(x); e.sa = 1'b1; e.sb = 1'b1; e.rw = 1'b1; end
            7'b1101111: begin e.pc = pc; e.rd = x[11:7]; e.imm = ij(x); e.sa = 1'b1; e.sb = 1'b1; e.rw = 1'b1; e.wb = 2'd2; end
            7'b1100111: begin e.pc = pc; e.rd = x[11:7]; e.rs1 = x[19:15]; e.rs1d = opnd(x[19:15]); e.f3 = f3;
                              e.imm = ii(x); e.sb = 1'b1; e.rw = 1'b1; e.wb = 2'd2; end
            7'b0000011: begin e.pc = pc; e.rd = x[11:7]; e.rs1 = x[19:15]; e.rs1d = opnd(x[19:15]); e.f3 = f3;
                              e.imm = ii(x); e.sb = 1'b1; e.mr = 1'b1; e.rw = 1'b1; e.wb = 2'd1; end
            7'b0100011: begin e.pc = pc; e.rs1 = x[19:15]; e.rs1d = opnd(x[19:15]); e.rs2 = x[24:20];
                              e.rs2d = opnd(x[24:20]); e.f3 = f3; e.imm = is_(x); e.sb = 1'b1; e.mw = 1'b1; end
            7'b0010011: begin e.pc = pc; e.rd = x[11:7]; e.rs1 = x[19:15]; e.rs1d = opnd(x[19:15]); e.f3 = f3;
                              e.imm = ii(x); e.op = (f3 == 3'd5 && x[30]) ? ALU_SRA : alu_tbl[f3]; e.sb = 1'b1; e.rw = 1'b1; end
            7'b0110011: begin e.pc = pc; e.rd = x[11:7]; e.rs1 = x[19:15]; e.rs1d = opnd(x[19:15]); e.rs2 = x[24:20];
                              e.rs2d = opnd(x[24:20]); e.f3 = f3; e.rw = 1'b1;
                              e.op = !x[30] ? alu_tbl[f3] : (f3 == 3'd0) ? ALU_SUB : (f3 == 3'd5) ? ALU_SRA : alu_tbl[f3]; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check_idex(input exp_t e);
        check("pc_ex", pc_ex, e.pc);
        check("rs1_data_ex", rs1_data_ex, e.rs1d);
        check("rs2_data_ex", rs2_data_ex, e.rs2d);
        check("imm_ex", imm_ex, e.imm);
        check("rs1_ex", 32'(rs1_ex), 32'(e.rs1));
        check("rs2_ex", 32'(rs2_ex), 32'(e.rs2));
        check("rd_ex", 32'(rd_ex), 32'(e.rd));
        check("funct3_ex", 32'(funct3_ex), 32'(e.f3));
        check("alu_op_ex", 32'(alu_op_ex), 32'(e.op));
        check("ctrl_ex", {25'd0, alu_src_a_ex, alu_src_b_ex, mem_read_ex, mem_write_ex, reg_write_ex, wb_sel_ex},
                         {25'd0, e.sa, e.sb, e.mr, e.mw, e.rw, e.wb});
    endtask

    // One ID cycle: drive, check redirect mid-cycle, check ID/EX after the edge, advance the model
    task automatic step(input logic [31:0] ins, input logic [31:0] addr, output logic jf, output logic [31:0] ja);
        logic [32:0] j;
        exp_t e;
        instruction_if = ins;
        instruction_address_if = addr;
        #4;
        j = model_jump(ins, addr - 32'd4);
        e = model_decode(ins, addr - 32'd4);
        jf = jump_flag_id;
        ja = jump_address_id;
        check("jump_flag_id", 32'(jump_flag_id), 32'(j[32]));
        check("jump_address_id", jump_address_id, j[31:0]);
        @(posedge clk);
        #1;
        check_idex(e);
        if (reg_write_wb && rd_wb != 5'd0) regs_m[rd_wb] = rd_data_wb;
        squash_m = j[32];
        reg_write_wb = 1'b0; rd_wb = 5'd0; rd_data_wb = 32'd0;
        reg_write_mem = 1'b0; mem_read_mem = 1'b0; rd_mem = 5'd0; alu_result_mem = 32'd0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [4:0]  a = 5'($urandom_range(0, 7));
        logic [4:0]  b = 5'($urandom_range(0, 7));
        logic [4:0]  d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
            0: return {r[31:12], d, 7'b0110111};
            1: return {r[31:12], d, 7'b0010111};
            2: return {r[31:12], d, 7'b1101111};
            3: return {r[31:20], a, 3'b000, d, 7'b1100111};
            4: return {r[31:25], b, a, r[14:12], r[11:7], 7'b1100011};
            5: return {r[31:20], a, r[14:12], d, 7'b0000011};
            6: return {r[31:25], b, a, r[14:12], r[11:7], 7'b0100011};
            7: return {r[31:20], a, r[14:12], d, 7'b0010011};
            8: return {1'b0, r[30], 5'b00000, b, a, r[14:12], d, 7'b0110011};
            9: return 32'h0000_0013;
            default: return r;
        endcase
    endfunction

    initial begin
        logic        jf;
        logic [31:0] ja;
        rst = 1'b1;
        instruction_if = 32'h0000_0013; instruction_address_if = 32'd0;
        reg_write_wb = 1'b0; rd_wb = 5'd0; rd_data_wb = 32'd0;
        reg_write_mem = 1'b0; mem_read_mem = 1'b0; rd_mem = 5'd0; alu_result_mem = 32'd0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
        squash_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_jump_flag", 32'(jump_flag_id), 32'd0);
        check_idex('0);
        rst = 1'b0;

        // addi x1,x0,5 with fetch PC 4
        step({12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'd4, jf, ja);
        check("addi_rd", 32'(rd_ex), 32'd1);
        check("addi_imm", imm_ex, 32'd5);
        check("addi_pc", pc_ex, 32'd0);
        check("addi_rw", 32'(reg_write_ex), 32'd1);

        // WB x2=0x1234 in the cycle add x3,x2,x0 reads it
        reg_write_wb = 1'b1; rd_wb = 5'd2; rd_data_wb = 32'h0000_1234;
        step({7'd0, 5'd0, 5'd2, 3'b000, 5'd3, 7'b0110011}, 32'd8, jf, ja);
        check("wb_bypass", rs1_data_ex, 32'h0000_1234);

        // WB write to x0 must not be visible
        reg_write_wb = 1'b1; rd_wb = 5'd0; rd_data_wb = 32'hDEAD_BEEF;
        step({7'd0, 5'd0, 5'd0, 3'b000, 5'd4, 7'b0110011}, 32'd12, jf, ja);
        check("x0_bypass", rs1_data_ex, 32'd0);
        reg_write_wb = 1'b1; rd_wb = 5'd1; rd_data_wb = 32'd5;
        step({7'd0, 5'd0, 5'd0, 3'b000, 5'd4, 7'b0110011}, 32'd16, jf, ja);
        check("x0_file", rs2_data_ex, 32'd0);

        // beq x1,x1,+16 at pc 8, then a squashed jal, then normal decode
        step(enc_b(16, 5'd1, 5'd1, 3'b000), 32'd12, jf, ja);
        check("beq_flag", 32'(jf), 32'd1);
        check("beq_target", ja, 32'd24);
        step(enc_j(100, 5'd1), 32'd28, jf, ja);
        check("squash_flag", 32'(jf), 32'd0);
        check("squash_rw", 32'(reg_write_ex), 32'd0);
        check("squash_rd", 32'(rd_ex), 32'd0);
        step({12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011}, 32'd32, jf, ja);
        check("resume_rd", 32'(rd_ex), 32'd5);

        // bne x1,x1 never taken, enters EX with no controls
        step(enc_b(16, 5'd1, 5'd1, 3'b001), 32'd36, jf, ja);
        check("bne_flag", 32'(jf), 32'd0);
        check("bne_ctrl", {27'd0, reg_write_ex, mem_read_ex, mem_write_ex, wb_sel_ex}, 32'd0);

        // jalr x1,0(x5) with MEM forwarding of x5
        reg_write_mem = 1'b1; rd_mem = 5'd5; alu_result_mem = 32'h0000_0080;
        step({12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111}, 32'd40, jf, ja);
        check("jalr_fwd", ja, 32'h0000_0080);
        reg_write_wb = 1'b1; rd_wb = 5'd5; rd_data_wb = 32'h0000_0200;
        step(32'h0000_0013, 32'h84, jf, ja);
        reg_write_mem = 1'b1; mem_read_mem = 1'b1; rd_mem = 5'd5; alu_result_mem = 32'h0000_0080;
        step({12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111}, 32'd48, jf, ja);
        check("jalr_load_nofwd", ja, 32'h0000_0200);
        step(32'h0000_0013, 32'h204, jf, ja);

        // Reset while a squash is pending
        step(enc_j(8, 5'd0), 32'd100, jf, ja);
        check("pre_reset_jal", 32'(jf), 32'd1);
        rst = 1'b1;
        instruction_if = 32'h0000_0013;
        #1;
        check("mid_reset_pc", pc_ex, 32'd0);
        check("mid_reset_rw", 32'(reg_write_ex), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
        squash_m = 1'b0;
        step(enc_j(8, 5'd0), 32'd200, jf, ja);
        check("post_reset_jal", 32'(jf), 32'd1);
        check("post_reset_target", ja, 32'd204);
        step(32'h0000_0013, 32'd208, jf, ja);
        step({7'd0, 5'd0, 5'd1, 3'b000, 5'd6, 7'b0110011}, 32'd212, jf, ja);
        check("rf_cleared", rs1_data_ex, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reg_write_wb   = 1'($urandom_range(0, 1));
            rd_wb          = 5'($urandom_range(0, 7));
            rd_data_wb     = $urandom;
            reg_write_mem  = 1'($urandom_range(0, 1));
            mem_read_mem   = ($urandom_range(0, 3) == 0);
            rd_mem         = 5'($urandom_range(0, 7));
            alu_result_mem = $urandom;
            step(rand_instr(), 32'($urandom_range(0, 4095)) << 2, jf, ja);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
ID stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. It consumes the fetched instruction and fetch PC, reads the 32x32 register file, and decodes the instruction. Branches and jumps are resolved in this stage and jump_flag_id/jump_address_id are driven back to fetch. Decoded control and operands are registered into the ID/EX pipeline register.

Parameters:
NOP_INSTR, 32'h0000_0013, instruction treated as bubble (addi x0,x0,0)
WB_BYPASS, 1, 1 = a register-file read of the register being written by WB in the same cycle returns the new data

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instruction_if  in  32  instruction register from fetch
instruction_address_if  in  32  fetch PC register (already advanced past instruction_if)
reg_write_wb  in  1  WB writes rd_wb
rd_wb  in  5  WB destination register
rd_data_wb  in  32  WB write data
reg_write_mem  in  1  MEM-stage instruction writes a register
mem_read_mem  in  1  MEM-stage instruction is a load (its ALU result is an address)
rd_mem  in  5  MEM destination register
alu_result_mem  in  32  MEM-stage ALU result
jump_flag_id  out  1  combinational: redirect fetch
jump_address_id  out  32  combinational: redirect target
pc_ex, rs1_data_ex, rs2_data_ex, imm_ex  out  32 each  ID/EX registered operands
rs1_ex, rs2_ex, rd_ex  out  5 each  ID/EX register indices
funct3_ex  out  3  ID/EX funct3 for load/store width
alu_op_ex  out  4  ID/EX ALU operation (package enum)
alu_src_a_ex  out  1  0 = rs1, 1 = pc
alu_src_b_ex  out  1  0 = rs2, 1 = imm
mem_read_ex, mem_write_ex, reg_write_ex  out  1 each  ID/EX control
wb_sel_ex  out  2  0 = ALU, 1 = memory, 2 = pc+4

Behaviour:
- PC of the instruction in ID: pc_id = instruction_address_if - 4, mod 2^32.
- Register file:
  - 32x32; x0 reads 0 and writes to it are ignored.
  - Synchronous write on posedge when reg_write_wb=1.
  - Asynchronous reset clears all registers to 0.
- Operand source priority for the branch compare, JALR base, and rs1/rs2_data_ex, applied per operand:
  - MEM: when reg_write_mem, mem_read_mem=0, rd_mem≠0, rd_mem matches.
  - Else WB: when WB_BYPASS, reg_write_wb, rd_wb≠0, rd_wb matches.
  - Else register file.
- No interlock. Software guarantees:
  - one independent instruction between a producer and a dependent branch/JALR;
  - two independent instructions after a load.
- Decode:
  - Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate formats I/S/B/U/J are sign-extended.
  - Any other opcode, and BRANCH with funct3 010/011, is illegal: bubble, no jump.
- Jump resolution (combinational):
  - JAL: target pc_id+immJ.
  - JALR: target (rs1+immI) & ~1.
  - Branch: target pc_id+immB, taken per funct3 (BEQ, BNE, BLT, BGE signed; BLTU, BGEU unsigned).
  - jump_flag_id=1 only when taken and the slot is not squashed.
  - jump_address_id=0 when jump_flag_id=0.
- Squash:
  - squash_q (1-bit register) is set at the edge where jump_flag_id=1; it is otherwise cleared.
  - While squash_q=1, the wrong-path instruction in ID is a bubble: jump_flag_id=0, ID/EX loads a bubble.
  - A squashed jump never redirects, and back-to-back redirects cannot occur.
- Bubble:
  - Controls: reg_write/mem_read/mem_write=0, rd_ex=0, alu_op=ADD, wb_sel=0.
  - Data fields: all zero.
  - An instruction equal to NOP_INSTR also decodes as a bubble.
- JAL/JALR: reg_write_ex=1, wb_sel_ex=2, pc_ex=pc_id (EX adds 4).
- Reset: all ID/EX outputs are 0 (bubble), squash_q=0, register file all 0. Asserting reset mid-operation discards any pending squash.
- Latency: one cycle from ID to EX. Redirect is same-cycle to fetch; exactly one wrong-path slot is squashed.

Decomposition:
- Shared package rv32_pkg: opcode constants, funct3 branch codes, alu_op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), wb_sel encoding, NOP_INSTR.
- One sub-module: register_file (2 async read ports, 1 write port, async reset, WB bypass).

Test Plan:
- Reset asserted with instruction_if=NOP: all ID/EX outputs 0, jump_flag_id=0. Release reset, feed addi x1,x0,5 with instruction_address_if=4: next edge rd_ex=1, imm_ex=5, pc_ex=0, reg_write_ex=1.
- WB writes x2=0x1234 in the same cycle ID reads add x3,x2,x0 → rs1_data_ex=0x1234. A WB write to x0 → x0 still reads 0.
- beq x1,x1 (imm 16) at pc 8, instruction_address_if=12:
  - jump_flag_id=1, jump_address_id=24.
  - Next cycle: a jal in ID is squashed (jump_flag_id=0, bubble in ID/EX).
  - Following cycle: normal decode resumes.
- bne x1,x1 not taken → jump_flag_id=0, bubble with no control asserted (all controls 0).
- MEM forwarding: rd_mem=5, alu_result_mem=0x80, reg_write_mem=1 with jalr x1,0(x5) → jump_address_id=0x80. Same with mem_read_mem=1 → register-file value is used.
- Reset asserted while squash_q=1 → squash_q=0. The first post-reset jump is taken normally.
